// File: rtl/blake2_stream_intf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_io_pkg
//  Purpose  : Shared command encoding and config-counter constants for the
//             BLAKE2 byte-stream interface.
//  Revision : 1.0  initial release
// ============================================================================
package blake2_io_pkg;

    typedef enum logic [1:0] {
        CMD_CONF  = 2'd0,
        CMD_START = 2'd1,
        CMD_DATA  = 2'd2,
        CMD_LAST  = 2'd3
    } cmd_e;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_BUSY = 1'b1
    } ser_state_e;

    localparam int CFG_CNT_W = 8;
    localparam logic [CFG_CNT_W-1:0] CFG_CNT_KK = 8'd0;
    localparam logic [CFG_CNT_W-1:0] CFG_CNT_NN = 8'd1;
    localparam logic [CFG_CNT_W-1:0] CFG_CNT_LL = 8'd2;

    // Saturation point: kk, nn, then every length byte.
    function automatic logic [CFG_CNT_W-1:0] cfg_cnt_max(input int ll_bytes);
        return CFG_CNT_W'(32'(CFG_CNT_LL) + ll_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blake2_stream_intf_if.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_stream_intf_if
//  Purpose  : Pin-side and core-side signal bundle of the BLAKE2 stream block.
//  Revision : 1.0  initial release
// ============================================================================
interface blake2_stream_intf_if #(
    parameter int DATA_BYTES = 1,
    parameter int LL_BYTES   = 8,
    parameter int HASH_BYTES = 32,
    parameter int IW         = 6
);
    import blake2_io_pkg::*;

    logic                    valid_i;
    logic                    ready_o;
    cmd_e                    cmd_i;
    logic [8*DATA_BYTES-1:0] data_i;
    logic [7:0]              kk_o;
    logic [7:0]              nn_o;
    logic [8*LL_BYTES-1:0]   ll_o;
    logic                    cfg_v_o;
    logic                    data_v_o;
    logic                    data_ready_i;
    logic [8*DATA_BYTES-1:0] data_o;
    logic [IW-1:0]           data_idx_o;
    logic                    block_first_o;
    logic                    block_last_o;
    logic                    hash_v_i;
    logic [8*HASH_BYTES-1:0] hash_i;
    logic                    hash_v_o;
    logic                    hash_ready_i;
    logic [7:0]              hash_o;
    logic                    hash_last_o;
    logic                    hash_drop_o;

    modport slave (
        input  valid_i, cmd_i, data_i, data_ready_i, hash_v_i, hash_i, hash_ready_i,
        output ready_o, kk_o, nn_o, ll_o, cfg_v_o, data_v_o, data_o, data_idx_o,
               block_first_o, block_last_o, hash_v_o, hash_o, hash_last_o, hash_drop_o
    );

    modport master (
        output valid_i, cmd_i, data_i, data_ready_i, hash_v_i, hash_i, hash_ready_i,
        input  ready_o, kk_o, nn_o, ll_o, cfg_v_o, data_v_o, data_o, data_idx_o,
               block_first_o, block_last_o, hash_v_o, hash_o, hash_last_o, hash_drop_o
    );

endinterface
`default_nettype wire

// File: rtl/blake2_stream_intf_hash_ser.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_hash_ser
//  Purpose  : Captures a finished digest and emits it one byte per accepted
//             cycle, byte 0 first.
//  Revision : 1.0  initial release
// ============================================================================
module blake2_hash_ser
    import blake2_io_pkg::*;
#(
    parameter int HASH_BYTES = 32
) (
    input  wire logic                    clk,
    input  wire logic                    nreset,
    input  wire logic [7:0]              nn_i,
    input  wire logic                    hash_v_i,
    input  wire logic [8*HASH_BYTES-1:0] hash_i,
    input  wire logic                    hash_ready_i,
    output logic                         hash_v_o,
    output logic [7:0]                   hash_o,
    output logic                         hash_last_o,
    output logic                         hash_drop_o
);
    localparam logic [7:0] LEN_MAX = 8'(HASH_BYTES);

    ser_state_e              state_q, state_d;
    logic [8*HASH_BYTES-1:0] buf_q, buf_d;
    logic [7:0]              rem_q, rem_d;
    logic                    drop_q, drop_d;
    logic [7:0]              len;
    logic                    byte_acc, final_acc, can_capture;

    assign len         = (nn_i == 8'd0 || nn_i > LEN_MAX) ? LEN_MAX : nn_i;
    assign byte_acc    = (state_q == SER_BUSY) && hash_ready_i;
    assign final_acc   = byte_acc && (rem_q == 8'd0);
    // A new digest may land in the same cycle the previous final byte leaves.
    assign can_capture = (state_q == SER_IDLE) || final_acc;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        drop_d  = hash_v_i && !can_capture;
        if (hash_v_i && can_capture) begin
            state_d = SER_BUSY;
            buf_d   = hash_i;
            rem_d   = len - 8'd1;
        end else if (final_acc) begin
            state_d = SER_IDLE;
            buf_d   = '0;
            rem_d   = '0;
        end else if (byte_acc) begin
            buf_d = buf_q >> 8;
            rem_d = rem_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= SER_IDLE;
            buf_q   <= '0;
            rem_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            drop_q  <= drop_d;
        end
    end

    assign hash_v_o    = (state_q == SER_BUSY);
    assign hash_o      = buf_q[7:0];
    assign hash_last_o = (state_q == SER_BUSY) && (rem_q == 8'd0);
    assign hash_drop_o = drop_q;

endmodule
`default_nettype wire

// File: rtl/blake2_stream_intf.sv
`default_nettype none
// ============================================================================
//  Module   : blake2_stream_intf
//  Purpose  : BLAKE2 byte-stream front/back end: config decode, indexed block
//             beats through a one-deep stage, serial digest output.
//  Revision : 1.0  initial release
// ============================================================================
module blake2_stream_intf
    import blake2_io_pkg::*;
#(
    parameter int DATA_BYTES  = 1,
    parameter int BLOCK_BYTES = 64,
    parameter int LL_BYTES    = 8,
    parameter int HASH_BYTES  = 32
) (
    input wire logic            clk,
    input wire logic            nreset,
    blake2_stream_intf_if.slave bus
);
    localparam int BEATS = BLOCK_BYTES / DATA_BYTES;
    localparam int IW    = $clog2(BEATS);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int LLW   = 8 * LL_BYTES;
    localparam logic [CFG_CNT_W-1:0] CFG_CNT_MAX = cfg_cnt_max(LL_BYTES);
    localparam logic [IW-1:0]        IDX_LAST    = IW'(BEATS - 1);

    logic [CFG_CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic [7:0]           kk_q, kk_d, nn_q, nn_d;
    logic [LLW-1:0]       ll_q, ll_d;
    logic                 cfg_v_q, cfg_v_d;
    logic                 data_v_q, data_v_d;
    logic [DW-1:0]        data_q, data_d;
    logic [IW-1:0]        idx_q, idx_d, next_idx_q, next_idx_d;
    logic                 first_q, first_d, last_q, last_d, first_blk_q, first_blk_d;
    logic                 is_conf, ready, conf_acc, blk_acc;

    // CONF beats bypass the stage, so they never see back-pressure.
    assign is_conf  = (bus.cmd_i == CMD_CONF);
    assign ready    = is_conf || !data_v_q || bus.data_ready_i;
    assign conf_acc = bus.valid_i && ready && is_conf;
    assign blk_acc  = bus.valid_i && ready && !is_conf;

    always_comb begin
        cfg_cnt_d = cfg_cnt_q;
        kk_d      = kk_q;
        nn_d      = nn_q;
        ll_d      = ll_q;
        cfg_v_d   = cfg_v_q;
        if (conf_acc && cfg_cnt_q != CFG_CNT_MAX) begin
            case (cfg_cnt_q)
                CFG_CNT_KK: kk_d = bus.data_i[7:0];
                CFG_CNT_NN: nn_d = bus.data_i[7:0];
                default:    ll_d = (ll_q << 8) | LLW'(bus.data_i[7:0]);
            endcase
            cfg_cnt_d = cfg_cnt_q + CFG_CNT_W'(1);
            cfg_v_d   = (cfg_cnt_d == CFG_CNT_MAX);
        end else if (blk_acc) begin
            cfg_cnt_d = '0;
        end
    end

    always_comb begin
        data_v_d    = data_v_q;
        data_d      = data_q;
        idx_d       = idx_q;
        first_d     = first_q;
        last_d      = last_q;
        next_idx_d  = next_idx_q;
        first_blk_d = first_blk_q;
        if (blk_acc) begin
            data_v_d = 1'b1;
            data_d   = bus.data_i;
            last_d   = (bus.cmd_i == CMD_LAST);
            if (bus.cmd_i == CMD_START) begin
                idx_d   = '0;
                first_d = 1'b1;
            end else begin
                idx_d   = next_idx_q;
                first_d = first_blk_q;
            end
            // A message end or block wrap both end the first-block window.
            next_idx_d  = (last_d || idx_d == IDX_LAST) ? '0 : idx_d + IW'(1);
            first_blk_d = first_d && !last_d && (idx_d != IDX_LAST);
        end else if (bus.data_ready_i) begin
            data_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cfg_cnt_q   <= '0;
            kk_q        <= '0;
            nn_q        <= '0;
            ll_q        <= '0;
            cfg_v_q     <= 1'b0;
            data_v_q    <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            next_idx_q  <= '0;
            first_blk_q <= 1'b0;
        end else begin
            cfg_cnt_q   <= cfg_cnt_d;
            kk_q        <= kk_d;
            nn_q        <= nn_d;
            ll_q        <= ll_d;
            cfg_v_q     <= cfg_v_d;
            data_v_q    <= data_v_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            last_q      <= last_d;
            next_idx_q  <= next_idx_d;
            first_blk_q <= first_blk_d;
        end
    end

    assign bus.ready_o       = ready;
    assign bus.kk_o          = kk_q;
    assign bus.nn_o          = nn_q;
    assign bus.ll_o          = ll_q;
    assign bus.cfg_v_o       = cfg_v_q;
    assign bus.data_v_o      = data_v_q;
    assign bus.data_o        = data_q;
    assign bus.data_idx_o    = idx_q;
    assign bus.block_first_o = first_q;
    assign bus.block_last_o  = last_q;

    blake2_hash_ser #(
        .HASH_BYTES (HASH_BYTES)
    ) u_hash_ser (
        .clk          (clk),
        .nreset       (nreset),
        .nn_i         (nn_q),
        .hash_v_i     (bus.hash_v_i),
        .hash_i       (bus.hash_i),
        .hash_ready_i (bus.hash_ready_i),
        .hash_v_o     (bus.hash_v_o),
        .hash_o       (bus.hash_o),
        .hash_last_o  (bus.hash_last_o),
        .hash_drop_o  (bus.hash_drop_o)
    );

endmodule
`default_nettype wire
